d16_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the d16 CPU data bus, downstream of the CPU alongside the LED register and RAM in the FPGA top. It decodes CPU bus writes to its address window, buffers bytes in a small FIFO, and serialises them as 8N1 frames on a single pin. Status and divisor registers are readable combinationally through the same bus read mux as RAM.

---
 rtl/d16_periph_pkg.sv | 15 +
 rtl/d16_uart_tx_if.sv | 13 +
 rtl/d16_fifo.sv | 41 ++++
 rtl/d16_uart_tx.sv | 123 ++++++++++++
 tb/tb_d16_uart_tx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/d16_periph_pkg.sv
// d16_periph_pkg: shared register offsets, STATUS bit positions and UART FSM states
//   REG_DATA/REG_STATUS/REG_DIV : word offsets from a peripheral's base address
//   STAT_*                      : bit positions inside the STATUS register
//   tx_state_e                  : transmitter FSM encoding
package d16_periph_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
endpackage

// File: rtl/d16_uart_tx_if.sv
// d16_uart_tx_if: d16 CPU data-bus slice seen by a memory-mapped peripheral
//   i_wb_addr/i_wb_cyc/i_wb_we/i_wb_dat : CPU -> peripheral (word address, cycle, write, data)
//   o_wb_dat/o_sel                      : peripheral -> CPU (combinational read data, window hit)
interface d16_uart_tx_if;
    logic [15:0] i_wb_addr;
    logic        i_wb_cyc;
    logic        i_wb_we;
    logic [15:0] i_wb_dat;
    logic [15:0] o_wb_dat;
    logic        o_sel;
    modport master (output i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat, input o_wb_dat, o_sel);
    modport slave  (input i_wb_addr, i_wb_cyc, i_wb_we, i_wb_dat, output o_wb_dat, o_sel);
endinterface

// File: rtl/d16_fifo.sv
// d16_fifo: synchronous FIFO, 2**DEPTH_LOG2 entries of WIDTH bits, first-word fall-through
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write strobe and data (caller never pushes when full unless popping)
//   pop_i/data_o  : read strobe and head entry (caller never pops when empty)
//   full_o/empty_o/count_o : occupancy
module d16_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= (push_i && !pop_i) ? cnt_q + 1'b1 : (!push_i && pop_i) ? cnt_q - 1'b1 : cnt_q;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
    assign data_o  = mem_q[rd_q];
    assign full_o  = cnt_q[DEPTH_LOG2];
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/d16_uart_tx.sv
// d16_uart_tx: memory-mapped 8N1 UART transmitter on the d16 CPU bus
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus              : d16_uart_tx_if slave (DATA +0 write, STATUS +1, DIV +2)
//   o_tx             : serial output, idle high
// Build option D16_UART_TX_FIFO_EN: 2**FIFO_DEPTH_LOG2-entry FIFO; otherwise a
// single-entry holding register.
module d16_uart_tx #(
    parameter logic [15:0] BASE_ADDR       = 16'h7010,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] DEFAULT_DIV     = 16'd433
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    d16_uart_tx_if.slave bus,
    output logic         o_tx
);
    import d16_periph_pkg::*;
    tx_state_e   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  idx_q;
    logic [15:0] cnt_q, div_q, off, status;
    logic        tx_q, ovf_q, wr, push, push_ok, pop, full, empty, bit_end;
    logic [7:0]  head, count8;
    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    assign off      = bus.i_wb_addr - BASE_ADDR;
    assign bus.o_sel = off < 16'd3;
    assign wr       = bus.i_wb_cyc && bus.i_wb_we && bus.o_sel;
    assign push     = wr && off[1:0] == REG_DATA;
    assign bit_end  = cnt_q == '0;
    assign pop      = !empty && (state_q == ST_IDLE || (state_q == ST_STOP && bit_end));
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push_ok  = push && (!full || pop);
`ifdef D16_UART_TX_FIFO_EN
    logic [FIFO_DEPTH_LOG2:0] fifo_cnt;
    d16_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .data_i  (bus.i_wb_dat[7:0]),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );
    assign count8 = 8'(fifo_cnt);
`else
    logic       hold_full_q;
    logic [7:0] hold_q;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            if (push_ok) hold_q <= bus.i_wb_dat[7:0];
            hold_full_q <= push_ok || (hold_full_q && !pop);
        end
    end
    assign full   = hold_full_q;
    assign empty  = !hold_full_q;
    assign head   = hold_q;
    assign count8 = {7'd0, hold_full_q};
`endif
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovf_q <= 1'b0;
            div_q <= DEFAULT_DIV;
        end else begin
            if (wr && off[1:0] == REG_STATUS) ovf_q <= 1'b0;
            else if (push && full && !pop) ovf_q <= 1'b1;
            if (wr && off[1:0] == REG_DIV) div_q <= bus.i_wb_dat;
        end
    end
    // Every bit start reloads the baud counter from div_q, so DIV writes land on the next bit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (pop) begin
                    shift_q <= head;
                    cnt_q   <= div_q;
                    tx_q    <= 1'b0;
                    state_q <= ST_START;
                end
                ST_START: if (bit_end) begin
                    idx_q   <= '0;
                    cnt_q   <= div_q;
                    tx_q    <= shift_q[0];
                    state_q <= ST_DATA;
                end else cnt_q <= cnt_q - 1'b1;
                ST_DATA: if (bit_end) begin
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 1'b1;
                    cnt_q   <= div_q;
                    tx_q    <= (idx_q == 3'd7) ? 1'b1 : shift_q[1];
                    state_q <= (idx_q == 3'd7) ? ST_STOP : ST_DATA;
                end else cnt_q <= cnt_q - 1'b1;
                ST_STOP: if (bit_end) begin
                    shift_q <= head;
                    cnt_q   <= div_q;
                    tx_q    <= !pop;
                    state_q <= pop ? ST_START : ST_IDLE;
                end else cnt_q <= cnt_q - 1'b1;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    always_comb begin
        status = '0;
        status[STAT_BUSY]     = state_q != ST_IDLE;
        status[STAT_FULL]     = full;
        status[STAT_EMPTY]    = empty;
        status[STAT_OVF]      = ovf_q;
        status[STAT_CNT +: 8] = count8;
    end
    assign bus.o_wb_dat = !bus.o_sel ? 16'h0000 : off[1:0] == REG_STATUS ? status : off[1:0] == REG_DIV ? div_q : 16'h0000;
    assign o_tx = tx_q;
endmodule

// File: tb/tb_d16_uart_tx.sv
// tb_d16_uart_tx: randomized and directed bench for d16_uart_tx against a frame-level model
module tb_d16_uart_tx;
    localparam logic [15:0] BASE = 16'h7010;
    localparam logic [15:0] DEF  = 16'd433;
`ifdef D16_UART_TX_FIFO_EN
    localparam int D = 8;
`else
    localparam int D = 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    int checks = 0;
    int errors = 0;
    d16_uart_tx_if bus();
    d16_uart_tx dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave), .o_tx(tx));
    always #5 clk = ~clk;

    // Model: queue of pending bytes plus the 10-bit frame currently on the wire.
    logic [7:0]  q[$];
    logic [15:0] div_m = DEF;
    logic        ovf_m = 1'b0;
    logic        active = 1'b0;
    logic        txm = 1'b1;
    logic [9:0]  bits = '0;
    int          bi = 0;
    int          rem = 0;
    logic [15:0] m_off;
    logic        m_wr, m_end;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        if (o == 16'd1) return {8'(q.size()), 4'b0, ovf_m, q.size() == 0, q.size() == D, active};
        if (o == 16'd2) return div_m;
        return 16'h0000;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            div_m = DEF; ovf_m = 1'b0; active = 1'b0; txm = 1'b1; bi = 0; rem = 0;
        end else begin
            m_off = bus.i_wb_addr - BASE;
            m_wr = bus.i_wb_cyc && bus.i_wb_we && m_off < 16'd3;
            m_end = 1'b0;
            if (active) begin
                if (rem == 0) begin
                    if (bi == 9) m_end = 1'b1;
                    else begin bi++; rem = int'(div_m); txm = bits[bi]; end
                end else rem--;
            end
            if (q.size() > 0 && (!active || m_end)) begin
                bits = {1'b1, q.pop_front(), 1'b0};
                bi = 0; rem = int'(div_m); txm = 1'b0; active = 1'b1;
            end else if (m_end) begin
                active = 1'b0; txm = 1'b1;
            end
            if (m_wr) begin
                if (m_off == 16'd0) begin
                    if (q.size() < D) q.push_back(bus.i_wb_dat[7:0]);
                    else ovf_m = 1'b1;
                end else if (m_off == 16'd1) ovf_m = 1'b0;
                else div_m = bus.i_wb_dat;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("tx", {15'd0, tx}, {15'd0, txm});
            chk("sel", {15'd0, bus.o_sel}, {15'd0, (bus.i_wb_addr - BASE) < 16'd3});
            chk("rdat", bus.o_wb_dat, exp_rd(bus.i_wb_addr));
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.i_wb_addr = a; bus.i_wb_dat = d; bus.i_wb_cyc = 1'b1; bus.i_wb_we = 1'b1;
        @(posedge clk); #2;
        bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        @(posedge clk); #2;
        bus.i_wb_addr = a; bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        #1 chk(name, bus.o_wb_dat, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active || q.size() > 0) && n < 5000) begin @(posedge clk); n++; end
        #2;
        checks++;
        if (n >= 5000) begin errors++; $display("FAIL drain: still busy after %0d cycles", n); end
    endtask

    logic [9:0]  exp55 = 10'b1010101010;
    logic [19:0] bb    = 20'b10000111101101000110;
    logic [15:0] ra;

    initial begin
        bus.i_wb_addr = 16'h0000; bus.i_wb_dat = 16'h0000; bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        rd("reset_status", BASE + 16'd1, 16'h0004);
        rd("reset_div", BASE + 16'd2, DEF);
        chk("reset_tx", {15'd0, tx}, 16'd1);
        wr(BASE - 16'd1, 16'h0055);
        wr(BASE + 16'd3, 16'h0001);
        rd("below_window", BASE - 16'd1, 16'h0000);
        chk("below_sel", {15'd0, bus.o_sel}, 16'd0);
        rd("above_window", BASE + 16'd3, 16'h0000);
        chk("above_sel", {15'd0, bus.o_sel}, 16'd0);
        rd("outside_status", BASE + 16'd1, 16'h0004);
        rd("outside_div", BASE + 16'd2, DEF);
        // 0x55 at DIV=3: each frame bit held 4 clocks starting one clock after the write.
        wr(BASE + 16'd2, 16'd3);
        wr(BASE, 16'h0055);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            chk("frame55", {15'd0, tx}, {15'd0, exp55[k/4]});
        end
        rd("after55_status", BASE + 16'd1, 16'h0004);
        // 0xA3 then 0x0F at DIV=1: contiguous frames, 2 clocks per bit.
        wr(BASE + 16'd2, 16'd1);
        wr(BASE, 16'h00A3);
        wr(BASE, 16'h000F);
        chk("b2b", {15'd0, tx}, {15'd0, bb[0]});
        for (int k = 1; k < 40; k++) begin
            @(posedge clk); #1;
            chk("b2b", {15'd0, tx}, {15'd0, bb[k/2]});
        end
        rd("after_b2b_status", BASE + 16'd1, 16'h0004);
        // DIV change during data bit 3 only stretches later bits.
        wr(BASE + 16'd2, 16'd3);
        wr(BASE, 16'h0018);
        repeat (17) @(posedge clk);
        #2 wr(BASE + 16'd2, 16'd7);
        repeat (2) @(posedge clk);
        #1 chk("div_bit3", {15'd0, tx}, 16'd1);
        repeat (8) @(posedge clk);
        #1 chk("div_bit4_end", {15'd0, tx}, 16'd1);
        @(posedge clk);
        #1 chk("div_bit5", {15'd0, tx}, 16'd0);
        wait_idle();
        // Overflow with the transmitter stalled by the largest divisor.
        wr(BASE + 16'd2, 16'hFFFF);
        for (int i = 0; i < D + 2; i++) wr(BASE, 16'(i + 1));
        rd("ovf_status", BASE + 16'd1, {8'(D), 8'h0B});
        wr(BASE + 16'd1, 16'h0000);
        rd("ovf_clear", BASE + 16'd1, {8'(D), 8'h03});
        chk("pre_reset_tx", {15'd0, tx}, 16'd0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_tx", {15'd0, tx}, 16'd1);
        rd("in_reset_status", BASE + 16'd1, 16'h0004);
        rd("in_reset_div", BASE + 16'd2, DEF);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 9))
                0: ra = BASE - 16'd1;
                1: ra = BASE + 16'd3;
                2, 3, 4: ra = BASE;
                5, 6: ra = BASE + 16'd1;
                7, 8: ra = BASE + 16'd2;
                default: ra = 16'($urandom);
            endcase
            bus.i_wb_addr = ra;
            bus.i_wb_cyc = $urandom_range(0, 3) != 0;
            bus.i_wb_we = $urandom_range(0, 2) == 0;
            bus.i_wb_dat = (ra == BASE + 16'd2) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            @(posedge clk); #2;
        end
        bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0;
        wait_idle();
        rd("final_status", BASE + 16'd1, {15'd0, ovf_m} << 3 | 16'h0004);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
